// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one single-bit ALU between two
// requesters. The winner's op/operand are latched onto the ALU pins, held for
// SETTLE_CYCLES cycles, and the settled result is then returned to the winner
// with a one-cycle done pulse.
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1  // legal 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [1:0] a0,
  output logic       gnt0,
  output logic       done0,
  output logic       res0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [1:0] a1,
  output logic       gnt1,
  output logic       done1,
  output logic       res1,
  output logic       busy,
  output logic       alu_m,
  output logic       alu_s1,
  output logic       alu_s0,
  output logic [1:0] alu_a,
  input  logic       alu_result
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Counter load value: the count runs down to zero, so the capture edge is
  // SETTLE_CYCLES edges after the grant edge.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       last_r;   // requester granted most recently
  logic       win_r;    // requester owning the in-flight transaction
  logic       any_req_s;
  logic       win_s;

  // Arbitration: a lone requester always wins; a tie goes to the one not
  // served last.
  always_comb begin
    any_req_s = req0 | req1;
    win_s     = 1'b0;
    if (req0 && req1) begin
      win_s = ~last_r;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered; gnt/done default low so
  // each is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      last_r  <= 1'b1;
      win_r   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res0    <= 1'b0;
      res1    <= 1'b0;
      busy    <= 1'b0;
      alu_m   <= 1'b0;
      alu_s1  <= 1'b0;
      alu_s0  <= 1'b0;
      alu_a   <= 2'b00;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            if (win_s) begin
              alu_m  <= op1[2];
              alu_s1 <= op1[1];
              alu_s0 <= op1[0];
              alu_a  <= a1;
              gnt1   <= 1'b1;
            end else begin
              alu_m  <= op0[2];
              alu_s1 <= op0[1];
              alu_s0 <= op0[0];
              alu_a  <= a0;
              gnt0   <= 1'b1;
            end
            last_r  <= win_s;
            win_r   <= win_s;
            cnt_r   <= CNT_INIT;
            busy    <= 1'b1;
            state_r <= WAIT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (win_r) begin
              res1  <= alu_result;
              done1 <= 1'b1;
            end else begin
              res0  <= alu_result;
              done0 <= 1'b1;
            end
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: two instances (SETTLE_CYCLES=1 and 3), each with
// a behavioural ALU on its pins, checked against a round-robin reference model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural single-bit ALU: op = {M,S1,S0}
  function automatic logic alu_fn(input logic [2:0] op, input logic [1:0] a);
    logic r;
    case (op)
      3'b000:  r = a[0] ^ a[1];
      3'b001:  r = a[0] & a[1];
      3'b010:  r = ~(a[0] | a[1]);
      3'b011:  r = a[1];
      3'b100:  r = a[0] & a[1];
      3'b101:  r = a[0] | a[1];
      3'b110:  r = a[0] ^ a[1];
      3'b111:  r = ~a[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // DUT with SETTLE_CYCLES = 1
  logic       d1_req0, d1_req1, d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_res0, d1_res1;
  logic [2:0] d1_op0, d1_op1;
  logic [1:0] d1_a0, d1_a1, d1_alu_a;
  logic       d1_busy, d1_m, d1_s1, d1_s0, d1_result;
  logic       d1_ovr_en = 1'b0, d1_ovr = 1'b0;
  assign d1_result = d1_ovr_en ? d1_ovr : alu_fn({d1_m, d1_s1, d1_s0}, d1_alu_a);

  alu_arbiter #(.SETTLE_CYCLES(1)) u_d1 (
    .clk(clk), .rst(rst),
    .req0(d1_req0), .op0(d1_op0), .a0(d1_a0), .gnt0(d1_gnt0), .done0(d1_done0), .res0(d1_res0),
    .req1(d1_req1), .op1(d1_op1), .a1(d1_a1), .gnt1(d1_gnt1), .done1(d1_done1), .res1(d1_res1),
    .busy(d1_busy), .alu_m(d1_m), .alu_s1(d1_s1), .alu_s0(d1_s0), .alu_a(d1_alu_a),
    .alu_result(d1_result)
  );

  // DUT with SETTLE_CYCLES = 3
  logic       d3_req0, d3_req1, d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_res0, d3_res1;
  logic [2:0] d3_op0, d3_op1;
  logic [1:0] d3_a0, d3_a1, d3_alu_a;
  logic       d3_busy, d3_m, d3_s1, d3_s0, d3_result;
  logic       d3_ovr_en = 1'b0, d3_ovr = 1'b0;
  assign d3_result = d3_ovr_en ? d3_ovr : alu_fn({d3_m, d3_s1, d3_s0}, d3_alu_a);

  alu_arbiter #(.SETTLE_CYCLES(3)) u_d3 (
    .clk(clk), .rst(rst),
    .req0(d3_req0), .op0(d3_op0), .a0(d3_a0), .gnt0(d3_gnt0), .done0(d3_done0), .res0(d3_res0),
    .req1(d3_req1), .op1(d3_op1), .a1(d3_a1), .gnt1(d3_gnt1), .done1(d3_done1), .res1(d3_res1),
    .busy(d3_busy), .alu_m(d3_m), .alu_s1(d3_s1), .alu_s0(d3_s0), .alu_a(d3_alu_a),
    .alu_result(d3_result)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    d1_req0 = 1'b0; d1_req1 = 1'b0; d1_op0 = 3'b000; d1_op1 = 3'b000; d1_a0 = 2'b00; d1_a1 = 2'b00;
    d3_req0 = 1'b0; d3_req1 = 1'b0; d3_op0 = 3'b000; d3_op1 = 3'b000; d3_a0 = 2'b00; d3_a1 = 2'b00;
    d1_ovr_en = 1'b0; d1_ovr = 1'b0; d3_ovr_en = 1'b0; d3_ovr = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 1: async reset mid-cycle clears outputs immediately
  task automatic test_reset;
    logic [12:0] o1, o3;
    do_reset();
    d1_req0 = 1'b1; d1_op0 = 3'b111; d1_a0 = 2'b11;
    tick();
    checks++;
    if ({d1_gnt0, d1_busy, d1_m, d1_s1, d1_s0, d1_alu_a} !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_pre_state: got %b expected 1111111",
               {d1_gnt0, d1_busy, d1_m, d1_s1, d1_s0, d1_alu_a});
    end
    #2;
    rst = 1'b1;
    #1;
    o1 = {d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_res0, d1_res1, d1_busy, d1_m, d1_s1, d1_s0, d1_alu_a, 1'b0};
    o3 = {d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_res0, d3_res1, d3_busy, d3_m, d3_s1, d3_s0, d3_alu_a, 1'b0};
    checks++;
    if (o1 !== 13'd0) begin
      errors++;
      $display("FAIL reset_async_d1: got %b expected all zero", o1);
    end
    checks++;
    if (o3 !== 13'd0) begin
      errors++;
      $display("FAIL reset_async_d3: got %b expected all zero", o3);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 2: single transaction, SETTLE=1
  task automatic test_single;
    do_reset();
    d1_req0 = 1'b1; d1_op0 = 3'b101; d1_a0 = 2'b10;
    d1_ovr_en = 1'b1; d1_ovr = 1'b1;
    tick();
    checks++;
    if ({d1_gnt0, d1_gnt1, d1_busy, d1_done0} !== 4'b1010) begin
      errors++;
      $display("FAIL single_grant: got %b expected 1010", {d1_gnt0, d1_gnt1, d1_busy, d1_done0});
    end
    checks++;
    if ({d1_m, d1_s1, d1_s0, d1_alu_a} !== 5'b10110) begin
      errors++;
      $display("FAIL single_pins: got %b expected 10110", {d1_m, d1_s1, d1_s0, d1_alu_a});
    end
    d1_req0 = 1'b0;
    tick();
    checks++;
    if ({d1_done0, d1_done1, d1_res0, d1_res1, d1_gnt0, d1_busy} !== 6'b101000) begin
      errors++;
      $display("FAIL single_done: got %b expected 101000",
               {d1_done0, d1_done1, d1_res0, d1_res1, d1_gnt0, d1_busy});
    end
    d1_ovr_en = 1'b0;
  endtask

  // 3: both requesters held high -> alternating grants and dones
  task automatic test_round_robin;
    logic       last_m, w;
    logic [3:0] exp;
    logic       exp_res;
    do_reset();
    d1_op0 = 3'($urandom_range(0, 7)); d1_a0 = 2'($urandom_range(0, 3));
    d1_op1 = 3'($urandom_range(0, 7)); d1_a1 = 2'($urandom_range(0, 3));
    d1_req0 = 1'b1; d1_req1 = 1'b1;
    last_m = 1'b1;
    w = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 0) begin
        w = ~last_m;
        last_m = w;
        exp = w ? 4'b1000 : 4'b0100;
      end else begin
        exp = w ? 4'b0010 : 4'b0001;
      end
      checks++;
      if ({d1_gnt1, d1_gnt0, d1_done1, d1_done0} !== exp) begin
        errors++;
        $display("FAIL rr_cycle%0d: got gnt1,gnt0,done1,done0=%b expected %b",
                 k, {d1_gnt1, d1_gnt0, d1_done1, d1_done0}, exp);
      end
      if (k % 2 == 1) begin
        exp_res = w ? alu_fn(d1_op1, d1_a1) : alu_fn(d1_op0, d1_a0);
        checks++;
        if ((w ? d1_res1 : d1_res0) !== exp_res) begin
          errors++;
          $display("FAIL rr_res%0d: got %b expected %b", k, (w ? d1_res1 : d1_res0), exp_res);
        end
      end
    end
    d1_req0 = 1'b0; d1_req1 = 1'b0;
    tick();
  endtask

  // 4: SETTLE=3, result settles late and is captured at the third edge
  task automatic test_settle3;
    do_reset();
    d3_req0 = 1'b1; d3_op0 = 3'b000; d3_a0 = 2'b00;
    d3_ovr_en = 1'b1; d3_ovr = 1'b0;
    tick();
    checks++;
    if (d3_gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL settle_grant: got %b expected 1", d3_gnt0);
    end
    d3_req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d3_ovr = (i == 2) ? 1'b1 : 1'b0;
      checks++;
      if ({d3_busy, d3_done0, d3_res0} !== 3'b100) begin
        errors++;
        $display("FAIL settle_wait%0d: got busy,done0,res0=%b expected 100", i, {d3_busy, d3_done0, d3_res0});
      end
      tick();
    end
    checks++;
    if ({d3_busy, d3_done0, d3_res0, d3_done1} !== 4'b0110) begin
      errors++;
      $display("FAIL settle_done: got busy,done0,res0,done1=%b expected 0110",
               {d3_busy, d3_done0, d3_res0, d3_done1});
    end
    d3_ovr_en = 1'b0;
  endtask

  // 5: reset during WAIT aborts the transaction and restores tie priority
  task automatic test_reset_in_wait;
    do_reset();
    d3_req0 = 1'b1; d3_req1 = 1'b1; d3_op0 = 3'b111; d3_a0 = 2'b00;
    tick();
    checks++;
    if ({d3_gnt0, d3_gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL abort_first_grant: got %b expected 10", {d3_gnt0, d3_gnt1});
    end
    d3_req0 = 1'b0; d3_req1 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({d3_done0, d3_done1, d3_busy, d3_res0} !== 4'b0000) begin
        errors++;
        $display("FAIL abort_no_done%0d: got %b expected 0000", i, {d3_done0, d3_done1, d3_busy, d3_res0});
      end
    end
    d3_req0 = 1'b1; d3_req1 = 1'b1;
    tick();
    checks++;
    if ({d3_gnt0, d3_gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL abort_tie_after_reset: got %b expected 10", {d3_gnt0, d3_gnt1});
    end
    d3_req0 = 1'b0; d3_req1 = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({d3_done0, d3_res0} !== 2'b11) begin
      errors++;
      $display("FAIL abort_resume_done: got %b expected 11", {d3_done0, d3_res0});
    end
  endtask

  // 6: sweep all 32 {A,S0,S1,M} combinations through requester 1
  task automatic test_sweep;
    logic [4:0] v;
    logic       exp_res;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      d1_op1 = {v[0], v[1], v[2]};
      d1_a1  = v[4:3];
      exp_res = alu_fn(d1_op1, d1_a1);
      d1_req1 = 1'b1;
      tick();
      checks++;
      if ({d1_gnt1, d1_gnt0} !== 2'b10) begin
        errors++;
        $display("FAIL sweep_grant%0d: got %b expected 10", i, {d1_gnt1, d1_gnt0});
      end
      d1_req1 = 1'b0;
      tick();
      checks++;
      if ({d1_done1, d1_done0, d1_res1, d1_res0} !== {2'b10, exp_res, 1'b0}) begin
        errors++;
        $display("FAIL sweep_res%0d: got done1,done0,res1,res0=%b expected %b",
                 i, {d1_done1, d1_done0, d1_res1, d1_res0}, {2'b10, exp_res, 1'b0});
      end
    end
  endtask

  // Random request patterns and operands against the round-robin model
  task automatic test_random;
    logic       last_m, w;
    logic [1:0] r;
    logic [2:0] op_w;
    logic [1:0] a_w;
    logic       res_m [2];
    do_reset();
    last_m = 1'b1;
    res_m[0] = 1'b0; res_m[1] = 1'b0;
    for (int n = 0; n < 24; n++) begin
      r = 2'($urandom_range(1, 3));
      d1_req0 = r[0]; d1_req1 = r[1];
      d1_op0 = 3'($urandom_range(0, 7)); d1_a0 = 2'($urandom_range(0, 3));
      d1_op1 = 3'($urandom_range(0, 7)); d1_a1 = 2'($urandom_range(0, 3));
      w = (r == 2'b11) ? ~last_m : r[1];
      last_m = w;
      op_w = w ? d1_op1 : d1_op0;
      a_w  = w ? d1_a1 : d1_a0;
      tick();
      checks++;
      if ({d1_gnt1, d1_gnt0, d1_m, d1_s1, d1_s0, d1_alu_a} !== {w, ~w, op_w, a_w}) begin
        errors++;
        $display("FAIL rand_grant%0d: got %b expected %b", n,
                 {d1_gnt1, d1_gnt0, d1_m, d1_s1, d1_s0, d1_alu_a}, {w, ~w, op_w, a_w});
      end
      d1_req0 = 1'b0; d1_req1 = 1'b0;
      d1_op0 = 3'($urandom_range(0, 7)); d1_a0 = 2'($urandom_range(0, 3));
      d1_op1 = 3'($urandom_range(0, 7)); d1_a1 = 2'($urandom_range(0, 3));
      res_m[w] = alu_fn(op_w, a_w);
      tick();
      checks++;
      if ({d1_done1, d1_done0, d1_res1, d1_res0} !== {w, ~w, res_m[1], res_m[0]}) begin
        errors++;
        $display("FAIL rand_done%0d: got %b expected %b", n,
                 {d1_done1, d1_done0, d1_res1, d1_res0}, {w, ~w, res_m[1], res_m[0]});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_settle3();
    test_reset_in_wait();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
